updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
- Parametrised successor to the free-running 8-bit sequential counter.
- Adds up/down direction, programmable modulo limit, wrap or saturate mode, synchronous load/clear, a clock-enable prescaler and a terminal-count pulse.
- Used as the general timing/sequence counter in lab designs, driven by board clock and reset.

Parameters:
- WIDTH, 8, width of count value, limit and load value.
- PRESC_W, 4, width of prescaler divide input.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; prescaler advances only when 1.
- presc  in  PRESC_W  divide ratio minus one; tick every presc+1 enabled cycles.
- dir  in  1  1 = count up, 0 = count down.
- sat  in  1  0 = wrap mode, 1 = saturate mode.
- limit  in  WIDTH  upper bound; count range is 0..limit inclusive.
- clear  in  1  synchronous clear.
- load  in  1  synchronous load.
- load_val  in  WIDTH  value to load.
- value  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).
- at_zero  out  1  combinational, value == 0.
- at_limit  out  1  combinational, value == limit.

Behaviour:
- Reset (rst_n=0, async): value=0, prescaler count psc=0, tc=0. Count is held while rst_n=0. First count is possible on the first rising edge after release.
- Priority per edge: clear > load > tick > hold.
- clear: value<=0, psc<=0, tc<=0.
- load: value<=min(load_val, limit), psc<=0, tc<=0. load is honoured even when en=0.
- Prescaler:
  - tick = en && (psc == presc).
  - On tick, psc<=0. Else if en, psc<=psc+1. Else psc holds.
  - presc=0 gives a tick on every enabled cycle.
  - If presc is lowered below psc, no tick occurs until psc wraps at 2^PRESC_W. This is an accepted limitation and must not be "fixed".
- Tick, wrap mode (sat=0):
  - Up: value==limit -> 0 with tc; else value+1.
  - Down: value==0 -> limit with tc; else value-1.
- Tick, saturate mode (sat=1):
  - Up: value==limit holds, no tc. value+1==limit -> limit with tc. Else value+1.
  - Down: value==0 holds, no tc. value==1 -> 0 with tc. Else value-1.
- Out-of-range value (value > limit after limit was lowered): on the next tick value<=limit, with tc=1 in both modes and both directions.
- limit=0: wrap mode pulses tc on every tick with value fixed at 0. Saturate mode holds 0, no tc.
- tc rules:
  - tc is asserted for exactly one cycle, coincident with the updated value.
  - Deasserted on any edge without a qualifying tick.
- Arithmetic is unsigned WIDTH bits. No internal value ever exceeds 2^WIDTH-1; limit=2^WIDTH-1 must wrap correctly.
- dir, sat, limit and presc may change on any cycle and take effect on the same edge.

Decomposition:
- Package counter_pkg:
  - localparam defaults (WIDTH, PRESC_W).
  - typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_t.
  - typedef enum logic {MODE_WRAP=0, MODE_SAT=1} mode_t.
- Sub-module tick_prescaler: inputs clk, rst_n, en, presc, sync_clr (clear|load); output tick.

Test Plan:
- Reset/basic: rst_n low 3 cycles, then WIDTH=8, limit=255, dir=1, en=1, presc=0 -> value 0,1,2,… each cycle; after 256 ticks value=0 with tc=1 for one cycle.
- Modulo down-wrap: limit=9, dir=0, sat=0, start 0 -> value 9 with tc, then 8..0, 9 with tc; tc period 10 cycles.
- Saturate: limit=5, sat=1, dir=1, load_val=3 -> 4, 5 (tc=1), 5, 5 (tc=0). Then dir=0 -> 4…1, 0 (tc=1), then holds at 0.
- Prescaler: presc=3, en toggled 1,1,0,1,1 -> ticks only on the 4th enabled cycle; value increments once per 4 enabled cycles.
- Priority/limit change:
  - clear and load in the same cycle -> value=0.
  - load_val=200 with limit=50 -> value=50.
  - At value=40, set limit=20 -> next tick value=20, tc=1.
- Async reset mid-count: assert rst_n between edges at value=7 -> value=0 and tc=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared defaults and enumerations for the up/down counter block.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no handshakes).
package counter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 4;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;
    typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: tick is high on every (presc+1)th enabled cycle.
// Latency: tick is combinational from the registered prescaler count.
// Backpressure: none; en gates the advance, sync_clr restarts the count.
// Ports: clk, rst_n (async, active-low), en, presc (ratio minus one),
//        sync_clr (restart at 0), tick (count-enable strobe).
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               sync_clr,
    output logic               tick
);

    logic [PRESC_W-1:0] psc;

    // Equality only: if presc drops below psc the count must run all the way
    // round through 2^PRESC_W before it matches again.
    assign tick = en && (psc == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
        end else if (sync_clr || tick) begin
            psc <= '0;
        end else if (en) begin
            psc <= psc + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down modulo counter with wrap/saturate modes, load/clear and prescaled tick.
// Latency: value and tc update one clock after the qualifying tick/clear/load.
// Backpressure: none; en stalls the prescaler, clear > load > tick > hold.
// Ports: clk, rst_n (async, active-low), en, presc, dir, sat, limit, clear,
//        load, load_val; outputs value, tc (registered), at_zero, at_limit.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               dir,
    input  logic               sat,
    input  logic [WIDTH-1:0]   limit,
    input  logic               clear,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   value,
    output logic               tc,
    output logic               at_zero,
    output logic               at_limit
);

    logic             tick;
    dir_t             dir_e;
    mode_t            mode_e;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] nxt_value;
    logic             nxt_tc;
    logic [WIDTH-1:0] load_clamp;

    tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_tick_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .presc    (presc),
        .sync_clr (clear | load),
        .tick     (tick)
    );

    assign dir_e    = dir_t'(dir);
    assign mode_e   = mode_t'(sat);
    assign at_zero  = (value == '0);
    assign at_limit = (value == limit);

    assign load_clamp = (load_val > limit) ? limit : load_val;

    // Next state for a tick. inc_val/dec_val are only used where they cannot
    // overflow: up only when value < limit, down only when value > 0.
    always_comb begin
        inc_val   = value + 1'b1;
        dec_val   = value - 1'b1;
        nxt_value = value;
        nxt_tc    = 1'b0;
        if (value > limit) begin
            // Limit was lowered under the count: snap back in range.
            nxt_value = limit;
            nxt_tc    = 1'b1;
        end else if (dir_e == DIR_UP) begin
            if (value == limit) begin
                if (mode_e == MODE_WRAP) begin
                    nxt_value = '0;
                    nxt_tc    = 1'b1;
                end
            end else begin
                nxt_value = inc_val;
                nxt_tc    = (mode_e == MODE_SAT) && (inc_val == limit);
            end
        end else begin
            if (value == '0) begin
                if (mode_e == MODE_WRAP) begin
                    nxt_value = limit;
                    nxt_tc    = 1'b1;
                end
            end else begin
                nxt_value = dec_val;
                nxt_tc    = (mode_e == MODE_SAT) && (dec_val == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            tc    <= 1'b0;
        end else if (clear) begin
            value <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            value <= load_clamp;
            tc    <= 1'b0;
        end else if (tick) begin
            value <= nxt_value;
            tc    <= nxt_tc;
        end else begin
            tc    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: expected results are queued per edge
// and a separate monitor compares them just after each rising edge.
module tb_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] presc;
    logic       dir;
    logic       sat;
    logic [7:0] limit;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] value;
    logic       tc;
    logic       at_zero;
    logic       at_limit;

    typedef struct packed {
        logic [7:0] v;
        logic       tc;
        logic       z;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_fail   = 0;

    updown_counter #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .presc    (presc),
        .dir      (dir),
        .sat      (sat),
        .limit    (limit),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .value    (value),
        .tc       (tc),
        .at_zero  (at_zero),
        .at_limit (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp_v);
        num_checks++;
        if (act !== exp_v) begin
            num_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Called at a negedge after the inputs for the coming edge are set:
    // queues the hand-computed result of that edge and moves to the next negedge.
    task automatic step(input logic [7:0] ev, input logic etc);
        exp_t e;
        e.v  = ev;
        e.tc = etc;
        e.z  = (ev == 8'd0);
        e.l  = (ev == limit);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("value",    int'(value),    int'(e.v));
                check("tc",       int'(tc),       int'(e.tc));
                check("at_zero",  int'(at_zero),  int'(e.z));
                check("at_limit", int'(at_limit), int'(e.l));
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; presc = 4'd0; dir = 1'b1; sat = 1'b0;
        limit = 8'd255; clear = 1'b0; load = 1'b0; load_val = 8'd0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_value",   int'(value),   0);
        check("rst_tc",      int'(tc),      0);
        check("rst_at_zero", int'(at_zero), 1);

        // Free-run up through the full 8-bit range.
        rst_n = 1'b1; en = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            step(iv[7:0], i == 256);
        end
        step(8'd1, 1'b0);

        // Modulo-10 down-wrap.
        clear = 1'b1; step(8'd0, 1'b0); clear = 1'b0;
        limit = 8'd9; dir = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i == 0 || i == 10) step(8'd9, 1'b1);
            else                   step(8'(9 - i), 1'b0);
        end

        // Saturate up then down.
        limit = 8'd5; sat = 1'b1; dir = 1'b1; load_val = 8'd3; load = 1'b1;
        step(8'd3, 1'b0); load = 1'b0;
        step(8'd4, 1'b0); step(8'd5, 1'b1); step(8'd5, 1'b0); step(8'd5, 1'b0);
        dir = 1'b0;
        step(8'd4, 1'b0); step(8'd3, 1'b0); step(8'd2, 1'b0); step(8'd1, 1'b0);
        step(8'd0, 1'b1); step(8'd0, 1'b0); step(8'd0, 1'b0);

        // Prescaler divide-by-4 with an enable gap.
        sat = 1'b0; dir = 1'b1; limit = 8'd255; presc = 4'd3;
        clear = 1'b1; step(8'd0, 1'b0); clear = 1'b0;
        en = 1'b1; step(8'd0, 1'b0);
        en = 1'b1; step(8'd0, 1'b0);
        en = 1'b0; step(8'd0, 1'b0);
        en = 1'b1; step(8'd0, 1'b0);
        en = 1'b1; step(8'd1, 1'b0);
        step(8'd1, 1'b0); step(8'd1, 1'b0); step(8'd1, 1'b0); step(8'd2, 1'b0);

        // Priority and load clamping.
        presc = 4'd0;
        clear = 1'b1; load = 1'b1; load_val = 8'd77; step(8'd0, 1'b0);
        clear = 1'b0; load_val = 8'd200; limit = 8'd50; step(8'd50, 1'b0);
        load = 1'b0; en = 1'b0; limit = 8'd255;
        load = 1'b1; load_val = 8'd40; step(8'd40, 1'b0);
        load = 1'b0; step(8'd40, 1'b0);

        // Limit lowered below the count, wrap and saturate modes.
        en = 1'b1; limit = 8'd20; step(8'd20, 1'b1);
        step(8'd0, 1'b1);
        limit = 8'd255; load = 1'b1; load_val = 8'd30; step(8'd30, 1'b0);
        load = 1'b0; limit = 8'd10; sat = 1'b1; dir = 1'b0;
        step(8'd10, 1'b1); step(8'd9, 1'b0);

        // limit = 0.
        limit = 8'd0; sat = 1'b0; dir = 1'b1;
        step(8'd0, 1'b1); step(8'd0, 1'b1); step(8'd0, 1'b1);
        sat = 1'b1; step(8'd0, 1'b0);

        // Full-range wrap at 255 both directions.
        sat = 1'b0; limit = 8'd255; load = 1'b1; load_val = 8'd254;
        step(8'd254, 1'b0); load = 1'b0;
        step(8'd255, 1'b0); step(8'd0, 1'b1);
        dir = 1'b0; step(8'd255, 1'b1);

        // Async reset between edges while value=7 and tc=1.
        clear = 1'b1; step(8'd0, 1'b0); clear = 1'b0;
        limit = 8'd7; step(8'd7, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_value", int'(value), 0);
        check("async_rst_tc",    int'(tc),    0);
        @(negedge clk);
        check("rst_hold_value", int'(value), 0);
        rst_n = 1'b1;
        step(8'd7, 1'b1);
        step(8'd6, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
